// File: rtl/fp_pkg.sv
// Shared floating-point field widths and state encoding for the adder datapath.
// The adder-side blocks and the result packer both import this package.
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 24;
    localparam int WORD_W = EXP_W + MANT_W;

    localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fp_norm_unit.sv
// Working mantissa shift-left register and exponent down-counter for serial normalisation.
// A shift moves the mantissa one place toward the hidden bit and decrements the exponent.
module fp_norm_unit
    import fp_pkg::*;
#(
    parameter int EXP_W  = fp_pkg::EXP_W,
    parameter int MANT_W = fp_pkg::MANT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift_en,
    input  logic [EXP_W-1:0]  load_exp,
    input  logic [MANT_W-1:0] load_mant,
    output logic [EXP_W-1:0]  exp,
    output logic [MANT_W-1:0] mant,
    output logic              mant_zero,
    output logic              mant_msb,
    output logic              exp_zero,
    output logic              exp_max
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp  <= '0;
            mant <= '0;
        end else if (load) begin
            exp  <= load_exp;
            mant <= load_mant;
        end else if (shift_en) begin
            exp  <= exp - 1'b1;
            mant <= {mant[MANT_W-2:0], 1'b0};
        end
    end

    assign mant_zero = (mant == '0);
    assign mant_msb  = mant[MANT_W-1];
    assign exp_zero  = (exp == '0);
    assign exp_max   = (exp == {EXP_W{1'b1}});

endmodule

// File: rtl/fp_result_packer.sv
// Packs sign/exponent/mantissa fields from the FP adder into an IEEE-754 single word,
// normalising one bit per cycle and classifying zero, infinity and underflow.
module fp_result_packer
    import fp_pkg::*;
#(
    parameter int EXP_W  = fp_pkg::EXP_W,
    parameter int MANT_W = fp_pkg::MANT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sign,
    input  logic [EXP_W-1:0]         in_exp,
    input  logic [MANT_W-1:0]        in_mant,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MANT_W-1:0]  out_word,
    output logic                     out_zero,
    output logic                     out_inf,
    output logic                     out_underflow
);

    localparam int PW = EXP_W + MANT_W;

    state_t              state_q, state_d;
    logic                sign_q;
    logic                load, shift_en, done_d;
    logic [PW-1:0]       word_d;
    logic                zero_d, inf_d, uf_d;
    logic [EXP_W-1:0]    w_exp;
    logic [MANT_W-1:0]   w_mant;
    logic                mant_zero, mant_msb, exp_zero, exp_max;

    fp_norm_unit #(
        .EXP_W  (EXP_W),
        .MANT_W (MANT_W)
    ) u_norm (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .shift_en  (shift_en),
        .load_exp  (in_exp),
        .load_mant (in_mant),
        .exp       (w_exp),
        .mant      (w_mant),
        .mant_zero (mant_zero),
        .mant_msb  (mant_msb),
        .exp_zero  (exp_zero),
        .exp_max   (exp_max)
    );

    assign in_ready = (state_q == IDLE);

    // Priority order in NORM: zero, infinity, normalised, underflow, then shift.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        shift_en = 1'b0;
        done_d   = 1'b0;
        word_d   = '0;
        zero_d   = 1'b0;
        inf_d    = 1'b0;
        uf_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = NORM;
                end
            end
            NORM: begin
                done_d  = 1'b1;
                state_d = DONE;
                if (mant_zero) begin
                    word_d = {sign_q, {(PW-1){1'b0}}};
                    zero_d = 1'b1;
                end else if (exp_max) begin
                    word_d = {sign_q, {EXP_W{1'b1}}, {(MANT_W-1){1'b0}}};
                    inf_d  = 1'b1;
                end else if (mant_msb && !exp_zero) begin
                    word_d = {sign_q, w_exp, w_mant[MANT_W-2:0]};
                end else if (exp_zero) begin
                    word_d = {sign_q, {(PW-1){1'b0}}};
                    uf_d   = 1'b1;
                end else begin
                    done_d   = 1'b0;
                    shift_en = 1'b1;
                    state_d  = NORM;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) sign_q <= in_sign;
        end
    end

    // Result registers: written only on the terminal NORM cycle, held through backpressure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid     <= 1'b0;
            out_word      <= '0;
            out_zero      <= 1'b0;
            out_inf       <= 1'b0;
            out_underflow <= 1'b0;
        end else if (done_d) begin
            out_valid     <= 1'b1;
            out_word      <= word_d;
            out_zero      <= zero_d;
            out_inf       <= inf_d;
            out_underflow <= uf_d;
        end else if (state_q == DONE && out_ready) begin
            out_valid     <= 1'b0;
        end
    end

endmodule

// File: doc/fp_result_packer.md
# fp_result_packer

Packs the unpacked result of the floating-point adder into a single IEEE-754 single-precision word. It accepts the adder's output fields: sign, 8-bit biased exponent, and 24-bit mantissa with an explicit hidden bit. It normalises serially, one left shift per cycle, and classifies zero, infinity and underflow. The block is the output end of the adder datapath: it turns field-level results back into the packed word that the system bus carries.

## Interface
Parameters:
- EXP_W, 8, biased exponent width
- MANT_W, 24, mantissa width including hidden bit; word width = EXP_W + MANT_W = 32

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-low
- in_valid  input  1  result fields valid
- in_ready  output  1  block can accept fields
- in_sign  input  1  result sign
- in_exp  input  EXP_W  biased exponent
- in_mant  input  MANT_W  mantissa, bit MANT_W-1 = hidden bit
- out_valid  output  1  packed word valid
- out_ready  input  1  consumer accepts word
- out_word  output  32  {sign, exp, mant[MANT_W-2:0]}
- out_zero  output  1  result is ±0 from zero mantissa
- out_inf  output  1  result is ±infinity
- out_underflow  output  1  result flushed to ±0

## Operation
- FSM states are IDLE, NORM and DONE. in_ready = (state == IDLE).
- IDLE: when in_valid is high, capture sign, exp and mant into working registers and go to NORM.
- NORM evaluates the following checks once per cycle, in priority order:
  1. mant == 0: word = {sign, 31'b0}, out_zero=1, go to DONE.
  2. exp == 2^EXP_W-1: word = {sign, all-ones exp, 0 fraction}, out_inf=1, go to DONE.
  3. mant[MSB]==1 and exp != 0: word = {sign, exp, mant[MANT_W-2:0]}, go to DONE.
  4. exp == 0: word = {sign, 31'b0}, out_underflow=1, go to DONE. Denormals are flushed to zero, with or without the MSB set.
  5. Otherwise: mant <<= 1 (shift in 0), exp -= 1, stay in NORM.
- The exponent never wraps below 0: check 4 fires before any decrement at exp==0.
- Shift count is at most MANT_W-1 (23), because a nonzero mantissa reaches the MSB within 23 shifts.
- DONE: out_valid=1. out_word and the flags are held stable while out_ready is low. When out_ready is high, go to IDLE.
- in_valid is ignored outside IDLE, so no input buffering is needed.
- Flags are mutually exclusive. All flags are 0 for a normal result.

## Timing
- Reset (async assert, any state): state=IDLE, out_valid=0, out_word=0, all flags 0, working registers 0, in_ready=1 once asserted. An operation in progress when reset asserts is discarded.
- Fields are accepted at edge t. With k shifts needed, the terminal NORM evaluation happens at edge t+k+1, and out_valid is high from edge t+k+1 until the edge at which out_ready is sampled high.
- Latency runs from 1 cycle (already normalised, zero, inf) to 24 cycles (23 shifts).
- The out handshake completes on the edge where out_valid && out_ready. in_ready rises after that edge.
- Minimum initiation interval is 3 cycles, with no overlap between consecutive operations.
- out_word and the flags are registered, with no combinational path from the inputs.

## Structure
- Shared package fp_pkg holds EXP_W, MANT_W, EXP_MAX (all-ones exponent), the packed-word width, and the FSM state enum (IDLE/NORM/DONE). The adder-side blocks reuse the package.
- Sub-module fp_norm_unit holds the working mantissa shift-left register and the exponent down-counter. It has load, shift/decrement enable, and zero/MSB/exp-zero/exp-max status outputs.
- The top level holds the FSM, the packing mux and the output registers.

## Test plan
- Normal: sign=0, exp=0x7F, mant=0x800000, out_ready=1. Required: out_word=0x3F800000 with no flags, out_valid 1 cycle after accept.
- Max shift: exp=0x82, mant=0x000001. Required: 23 shifts, out_word=0x35800000, out_valid 24 cycles after accept.
- Zero: sign=1, exp=0x55, mant=0. Required: out_word=0x80000000 with out_zero=1, 1-cycle latency.
- Underflow: exp=0x03, mant=0x100000. Required: after 3 shifts exp=0 with MSB set, so out_word=0x00000000 with out_underflow=1.
- Infinity: exp=0xFF, mant=0xC00000. Required: out_word=0x7F800000 with out_inf=1.
- Backpressure and reset:
  - Hold out_ready low for 5 cycles. Required: out_word is stable, in_ready=0, and in_valid pulses are ignored.
  - Then assert rst mid-NORM on a new operation. Required: out_valid=0 and in_ready=1 immediately, and the next operation is packed correctly.
